stage_3: RTL

Third and final pipeline stage of the entropy encoder. It consumes the normalized range, shift amount `d` and interval bounds produced by stage 2, and maintains the architectural `low` register and bit counter `cnt`. It emits up to two pre-carry bytes per accepted symbol and drives the registered range back to stage 1. A flush FSM drains the remaining bits at end of tile. Carry resolution happens downstream; each emitted word carries its own carry bit.

---
 rtl/stage_3_if.sv | 33 +++
 rtl/stage_3.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stage_3_if.sv
// Bundle between entropy-encoder stage 2 and stage 3: symbol operands in,
// pre-carry words, range feedback and flush handshake out.
interface stage_3_if #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 5,
  parameter int OUT_WIDTH   = 9
);
  logic                   in_valid;
  logic [RANGE_WIDTH:0]   u;
  logic [RANGE_WIDTH:0]   v_bool;
  logic [RANGE_WIDTH-1:0] initial_range;
  logic [RANGE_WIDTH-1:0] in_range;
  logic [D_SIZE-1:0]      in_d;
  logic [1:0]             bool_symbol;
  logic                   COMP_mux_1;
  logic                   flush;
  logic [RANGE_WIDTH-1:0] range_out;
  logic [OUT_WIDTH-1:0]   out_word_1;
  logic [OUT_WIDTH-1:0]   out_word_2;
  logic [1:0]             out_flag;
  logic                   busy;
  logic                   done;

  modport master (
    output in_valid, u, v_bool, initial_range, in_range, in_d, bool_symbol, COMP_mux_1, flush,
    input  range_out, out_word_1, out_word_2, out_flag, busy, done
  );

  modport slave (
    input  in_valid, u, v_bool, initial_range, in_range, in_d, bool_symbol, COMP_mux_1, flush,
    output range_out, out_word_1, out_word_2, out_flag, busy, done
  );
endinterface

// File: rtl/stage_3.sv
// Final entropy-encoder stage: owns low/cnt, emits up to two pre-carry bytes
// per symbol and drains the remaining bits of low when a flush is requested.
module stage_3 #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 5,
  parameter int LOW_WIDTH   = 24,
  parameter int OUT_WIDTH   = 9
) (
  input logic      clk,
  input logic      reset,
  stage_3_if.slave bus
);
  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic signed [5:0]      CNT_INIT   = -6'sd9;
  localparam logic [RANGE_WIDTH-1:0] RANGE_INIT = RANGE_WIDTH'(1) << (RANGE_WIDTH - 1);
  localparam logic [LOW_WIDTH:0]     E_MASK     = (LOW_WIDTH+1)'(16'h3FFF);
  localparam logic [LOW_WIDTH:0]     E_ONE      = (LOW_WIDTH+1)'(16'h4000);

  state_t                  state_reg;
  logic [LOW_WIDTH-1:0]    low_reg;
  logic signed [5:0]       cnt_reg;
  logic [RANGE_WIDTH-1:0]  range_reg;
  logic [OUT_WIDTH-1:0]    word_1_reg, word_2_reg;
  logic [1:0]              flag_reg;
  logic                    busy_reg, done_reg;
  logic [LOW_WIDTH:0]      e_reg;
  logic signed [6:0]       sf_reg, cf_reg;

  logic [D_SIZE-1:0]       d_val;
  logic [RANGE_WIDTH-1:0]  add_term;
  logic [LOW_WIDTH:0]      l_sum, l_rem, e_init;
  logic signed [6:0]       cnt_ext, d_ext, s_val, c_val, sf_init, cf_init;
  logic [1:0]              run_flag;
  logic [OUT_WIDTH-1:0]    run_w1, run_w2, flush_word;
  logic [LOW_WIDTH-1:0]    low_upd, low_post;
  logic signed [5:0]       cnt_upd, cnt_post;
  logic [4:0]              flush_sh;
  logic                    unused_top_bits;

  function automatic logic [LOW_WIDTH:0] low_mask(input logic [4:0] n);
    return ((LOW_WIDTH+1)'(1) << n) - (LOW_WIDTH+1)'(1);
  endfunction

  assign d_val           = bus.in_d;
  assign unused_top_bits = bus.u[RANGE_WIDTH] ^ bus.v_bool[RANGE_WIDTH];

  always_comb begin
    add_term = '0;
    if (bus.bool_symbol[1]) begin
      if (bus.bool_symbol[0]) add_term = bus.initial_range - bus.v_bool[RANGE_WIDTH-1:0];
    end else if (bus.COMP_mux_1) begin
      add_term = bus.initial_range - bus.u[RANGE_WIDTH-1:0];
    end
    l_sum    = {1'b0, low_reg} + (LOW_WIDTH+1)'(add_term);
    cnt_ext  = {cnt_reg[5], cnt_reg};
    d_ext    = 7'(d_val);
    s_val    = cnt_ext + d_ext;
    c_val    = cnt_ext + 7'sd16;
    l_rem    = l_sum;
    run_flag = 2'd0;
    run_w1   = '0;
    run_w2   = '0;
    low_upd  = LOW_WIDTH'(l_sum << d_val);
    cnt_upd  = s_val[5:0];
    // A non-negative s means at least one whole byte sits above bit c of l.
    if (!s_val[6]) begin
      run_w1   = OUT_WIDTH'(l_sum >> c_val[4:0]);
      l_rem    = l_sum & low_mask(c_val[4:0]);
      run_flag = 2'd1;
      if (s_val >= 7'sd8) begin
        c_val    = c_val - 7'sd8;
        run_w2   = OUT_WIDTH'(l_rem >> c_val[4:0]);
        l_rem    = l_rem & low_mask(c_val[4:0]);
        run_flag = 2'd2;
      end
      low_upd = LOW_WIDTH'(l_rem << d_val);
      cnt_upd = 6'(c_val + d_ext - 7'sd24);
    end
    // A flush in the same cycle as a symbol drains the post-symbol state.
    low_post = bus.in_valid ? low_upd : low_reg;
    cnt_post = bus.in_valid ? cnt_upd : cnt_reg;
    e_init   = ((((LOW_WIDTH+1)'(low_post)) + E_MASK) & ~E_MASK) | E_ONE;
    cf_init  = {cnt_post[5], cnt_post};
    sf_init  = cf_init + 7'sd10;
  end

  assign flush_sh   = 5'(cf_reg + 7'sd16);
  assign flush_word = OUT_WIDTH'(e_reg >> flush_sh);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= RUN;
      low_reg    <= '0;
      cnt_reg    <= CNT_INIT;
      range_reg  <= RANGE_INIT;
      word_1_reg <= '0;
      word_2_reg <= '0;
      flag_reg   <= 2'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      e_reg      <= '0;
      sf_reg     <= '0;
      cf_reg     <= '0;
    end else begin
      flag_reg <= 2'd0;
      done_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (bus.in_valid) begin
            low_reg   <= low_upd;
            cnt_reg   <= cnt_upd;
            range_reg <= bus.in_range;
            flag_reg  <= run_flag;
            if (run_flag != 2'd0) word_1_reg <= run_w1;
            if (run_flag == 2'd2) word_2_reg <= run_w2;
          end
          if (bus.flush) begin
            if (sf_init > 7'sd0) begin
              state_reg <= FLUSH;
              busy_reg  <= 1'b1;
              e_reg     <= e_init;
              sf_reg    <= sf_init;
              cf_reg    <= cf_init;
            end else begin
              done_reg  <= 1'b1;
              low_reg   <= '0;
              cnt_reg   <= CNT_INIT;
              range_reg <= RANGE_INIT;
            end
          end
        end
        FLUSH: begin
          word_1_reg <= flush_word;
          flag_reg   <= 2'd1;
          e_reg      <= e_reg & low_mask(flush_sh);
          sf_reg     <= sf_reg - 7'sd8;
          cf_reg     <= cf_reg - 7'sd8;
          if (sf_reg <= 7'sd8) begin
            state_reg <= RUN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            low_reg   <= '0;
            cnt_reg   <= CNT_INIT;
            range_reg <= RANGE_INIT;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign bus.range_out  = range_reg;
  assign bus.out_word_1 = word_1_reg;
  assign bus.out_word_2 = word_2_reg;
  assign bus.out_flag   = flag_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
endmodule
